// File: rtl/rs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rs_pkg : shared widths, ALU opcode encoding and entry layout for rs_cdb     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package rs_pkg;

    localparam int ROB_W_DEF = 4;
    localparam int XLEN_DEF  = 32;
    localparam int OP_W_DEF  = 4;

    // Encoding is {op_L1[2:0], op_L2}
    typedef enum logic [OP_W_DEF-1:0] {
        ALU_ADD  = 4'b000_0,
        ALU_SUB  = 4'b000_1,
        ALU_SLL  = 4'b001_0,
        ALU_SLT  = 4'b010_0,
        ALU_SLTU = 4'b011_0,
        ALU_XOR  = 4'b100_0,
        ALU_SRL  = 4'b101_0,
        ALU_SRA  = 4'b101_1,
        ALU_OR   = 4'b110_0,
        ALU_AND  = 4'b111_0
    } alu_op_t;

    typedef struct packed {
        logic                 busy;
        logic [OP_W_DEF-1:0]  op;
        logic [XLEN_DEF-1:0]  v1;
        logic [XLEN_DEF-1:0]  v2;
        logic                 q1v;
        logic                 q2v;
        logic [ROB_W_DEF-1:0] q1;
        logic [ROB_W_DEF-1:0] q2;
        logic [ROB_W_DEF-1:0] rob_id;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/rs_age_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rs_age_picker : age matrix tracking entry order, one-hot oldest-ready grant |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rs_age_picker #(
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             flush_in,
    input  logic [DEPTH-1:0] busy_in,
    input  logic [DEPTH-1:0] alloc_in,
    input  logic [DEPTH-1:0] free_in,
    input  logic [DEPTH-1:0] ready_in,
    output logic [DEPTH-1:0] grant_out,
    output logic             any_out
);

    // age_q[i][j] = 1 means entry i is older than entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
        end
        if (en_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (flush_in || (i == j) || free_in[i] || free_in[j]) begin
                        age_d[i][j] = 1'b0;
                    end else if (alloc_in[j]) begin
                        age_d[i][j] = busy_in[i];
                    end else if (alloc_in[i]) begin
                        age_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // An entry wins when no other ready entry is older than it
    always_comb begin
        grant_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_in[j] && age_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            grant_out[i] = ready_in[i] & ~blocked;
        end
        any_out = |ready_in;
    end

endmodule
`default_nettype wire

// File: rtl/rs_cdb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rs_cdb : reservation station with CDB snooping and valid/ready issue reg    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rs_cdb
    import rs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       disp_valid_in,
    output logic                       disp_ready_out,
    input  logic [OP_W-1:0]            disp_op_in,
    input  logic [XLEN-1:0]            disp_v1_in,
    input  logic [XLEN-1:0]            disp_v2_in,
    input  logic                       disp_q1_valid_in,
    input  logic                       disp_q2_valid_in,
    input  logic [ROB_W-1:0]           disp_q1_in,
    input  logic [ROB_W-1:0]           disp_q2_in,
    input  logic [ROB_W-1:0]           disp_rob_id_in,
    input  logic [NUM_CDB-1:0]         cdb_valid_in,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id_in,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_value_in,
    output logic                       issue_valid_out,
    input  logic                       issue_ready_in,
    output logic [OP_W-1:0]            issue_op_out,
    output logic [XLEN-1:0]            issue_opr1_out,
    output logic [XLEN-1:0]            issue_opr2_out,
    output logic [ROB_W-1:0]           issue_rob_id_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic             q1v;
        logic             q2v;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
        logic [ROB_W-1:0] rob_id;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q, count_d;
    logic             issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]  issue_op_q, issue_op_d;
    logic [XLEN-1:0]  issue_opr1_q, issue_opr1_d;
    logic [XLEN-1:0]  issue_opr2_q, issue_opr2_d;
    logic [ROB_W-1:0] issue_rob_q, issue_rob_d;

    logic [ROB_W-1:0] cdb_tag [NUM_CDB];
    logic [XLEN-1:0]  cdb_val [NUM_CDB];
    logic [DEPTH-1:0] busy_vec, ready_vec, alloc_oh, free_oh, grant;
    logic             pick_any, accept, load;
    logic [IDX_W-1:0] free_idx, sel_idx;

    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            cdb_tag[c] = cdb_rob_id_in[c*ROB_W +: ROB_W];
            cdb_val[c] = cdb_value_in[c*XLEN +: XLEN];
        end
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ~ent_q[i].q1v & ~ent_q[i].q2v;
        end
    end

    always_comb begin
        logic found_free, found_sel;
        free_idx   = '0;
        sel_idx    = '0;
        found_free = 1'b0;
        found_sel  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found_free && !busy_vec[i]) begin
                free_idx   = IDX_W'(i);
                found_free = 1'b1;
            end
            if (!found_sel && grant[i]) begin
                sel_idx   = IDX_W'(i);
                found_sel = 1'b1;
            end
        end
    end

    assign disp_ready_out = (count_q != CNT_W'(DEPTH));
    assign accept   = disp_valid_in & disp_ready_out & rdy_in & ~flush_in;
    assign load     = rdy_in & ~flush_in & pick_any & (~issue_valid_q | issue_ready_in);
    assign alloc_oh = accept ? (DEPTH'(1) << free_idx) : '0;
    assign free_oh  = load ? grant : '0;

    rs_age_picker #(
        .DEPTH (DEPTH)
    ) u_picker (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (rdy_in),
        .flush_in  (flush_in),
        .busy_in   (busy_vec),
        .alloc_in  (alloc_oh),
        .free_in   (free_oh),
        .ready_in  (ready_vec),
        .grant_out (grant),
        .any_out   (pick_any)
    );

    // Channels scanned high to low so the lowest matching channel is written last
    always_comb begin
        new_ent        = '0;
        new_ent.busy   = 1'b1;
        new_ent.op     = disp_op_in;
        new_ent.v1     = disp_v1_in;
        new_ent.v2     = disp_v2_in;
        new_ent.q1v    = disp_q1_valid_in;
        new_ent.q2v    = disp_q2_valid_in;
        new_ent.q1     = disp_q1_in;
        new_ent.q2     = disp_q2_in;
        new_ent.rob_id = disp_rob_id_in;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid_in[c] && disp_q1_valid_in && (disp_q1_in == cdb_tag[c])) begin
                new_ent.v1  = cdb_val[c];
                new_ent.q1v = 1'b0;
            end
            if (cdb_valid_in[c] && disp_q2_valid_in && (disp_q2_in == cdb_tag[c])) begin
                new_ent.v2  = cdb_val[c];
                new_ent.q2v = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    for (int c = NUM_CDB - 1; c >= 0; c--) begin
                        if (cdb_valid_in[c] && ent_q[i].busy && ent_q[i].q1v &&
                            (ent_q[i].q1 == cdb_tag[c])) begin
                            ent_d[i].v1  = cdb_val[c];
                            ent_d[i].q1v = 1'b0;
                        end
                        if (cdb_valid_in[c] && ent_q[i].busy && ent_q[i].q2v &&
                            (ent_q[i].q2 == cdb_tag[c])) begin
                            ent_d[i].v2  = cdb_val[c];
                            ent_d[i].q2v = 1'b0;
                        end
                    end
                end
                if (load) begin
                    ent_d[sel_idx].busy = 1'b0;
                end
                // The free slot comes from registered busy, so a slot freed by load is never reused here
                if (accept) begin
                    ent_d[free_idx] = new_ent;
                end
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_opr1_d  = issue_opr1_q;
        issue_opr2_d  = issue_opr2_q;
        issue_rob_d   = issue_rob_q;
        count_d       = count_q;
        if (rdy_in) begin
            if (flush_in) begin
                issue_valid_d = 1'b0;
                count_d       = '0;
            end else begin
                if (load) begin
                    issue_valid_d = 1'b1;
                    issue_op_d    = ent_q[sel_idx].op;
                    issue_opr1_d  = ent_q[sel_idx].v1;
                    issue_opr2_d  = ent_q[sel_idx].v2;
                    issue_rob_d   = ent_q[sel_idx].rob_id;
                end else if (issue_valid_q && issue_ready_in) begin
                    issue_valid_d = 1'b0;
                end
                count_d = count_q + CNT_W'(accept) - CNT_W'(load);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_opr1_q  <= '0;
            issue_opr2_q  <= '0;
            issue_rob_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_opr1_q  <= issue_opr1_d;
            issue_opr2_q  <= issue_opr2_d;
            issue_rob_q   <= issue_rob_d;
        end
    end

    assign issue_valid_out  = issue_valid_q;
    assign issue_op_out     = issue_op_q;
    assign issue_opr1_out   = issue_opr1_q;
    assign issue_opr2_out   = issue_opr2_q;
    assign issue_rob_id_out = issue_rob_q;
    assign count_out        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_cdb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rs_cdb : directed self-checking bench for rs_cdb                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rs_cdb;
    import rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        disp_valid_in;
    logic        disp_ready_out;
    logic [3:0]  disp_op_in;
    logic [31:0] disp_v1_in, disp_v2_in;
    logic        disp_q1_valid_in, disp_q2_valid_in;
    logic [3:0]  disp_q1_in, disp_q2_in, disp_rob_id_in;
    logic [1:0]  cdb_valid_in;
    logic [7:0]  cdb_rob_id_in;
    logic [63:0] cdb_value_in;
    logic        issue_valid_out;
    logic        issue_ready_in;
    logic [3:0]  issue_op_out;
    logic [31:0] issue_opr1_out, issue_opr2_out;
    logic [3:0]  issue_rob_id_out;
    logic [3:0]  count_out;

    int n_tests = 0;
    int n_fail  = 0;

    rs_cdb u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush_in         (flush_in),
        .disp_valid_in    (disp_valid_in),
        .disp_ready_out   (disp_ready_out),
        .disp_op_in       (disp_op_in),
        .disp_v1_in       (disp_v1_in),
        .disp_v2_in       (disp_v2_in),
        .disp_q1_valid_in (disp_q1_valid_in),
        .disp_q2_valid_in (disp_q2_valid_in),
        .disp_q1_in       (disp_q1_in),
        .disp_q2_in       (disp_q2_in),
        .disp_rob_id_in   (disp_rob_id_in),
        .cdb_valid_in     (cdb_valid_in),
        .cdb_rob_id_in    (cdb_rob_id_in),
        .cdb_value_in     (cdb_value_in),
        .issue_valid_out  (issue_valid_out),
        .issue_ready_in   (issue_ready_in),
        .issue_op_out     (issue_op_out),
        .issue_opr1_out   (issue_opr1_out),
        .issue_opr2_out   (issue_opr2_out),
        .issue_rob_id_out (issue_rob_id_out),
        .count_out        (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid_in    = 1'b0;
        disp_op_in       = '0;
        disp_v1_in       = '0;
        disp_v2_in       = '0;
        disp_q1_valid_in = 1'b0;
        disp_q2_valid_in = 1'b0;
        disp_q1_in       = '0;
        disp_q2_in       = '0;
        disp_rob_id_in   = '0;
        cdb_valid_in     = '0;
        cdb_rob_id_in    = '0;
        cdb_value_in     = '0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic q1v, input logic q2v, input logic [3:0] q1,
                        input logic [3:0] q2, input logic [3:0] rob);
        disp_valid_in    = 1'b1;
        disp_op_in       = op;
        disp_v1_in       = v1;
        disp_v2_in       = v2;
        disp_q1_valid_in = q1v;
        disp_q2_valid_in = q2v;
        disp_q1_in       = q1;
        disp_q2_in       = q2;
        disp_rob_id_in   = rob;
    endtask

    task automatic cdb(input logic [1:0] vld, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [31:0] val0, input logic [31:0] val1);
        cdb_valid_in  = vld;
        cdb_rob_id_in = {t1, t0};
        cdb_value_in  = {val1, val0};
    endtask

    initial begin
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        flush_in       = 1'b0;
        issue_ready_in = 1'b0;
        idle();
        #2;
        chk("rst_count", count_out, 0);
        chk("rst_valid", issue_valid_out, 0);
        chk("rst_op", issue_op_out, 0);
        chk("rst_opr1", issue_opr1_out, 0);
        chk("rst_rob", issue_rob_id_out, 0);
        chk("rst_dready", disp_ready_out, 1);
        #10 rst_in = 1'b1;
        step();

        // ready op issues one cycle after dispatch
        issue_ready_in = 1'b1;
        disp(ALU_ADD, 5, 7, 0, 0, 0, 0, 3);
        step();
        chk("rd_count1", count_out, 1);
        chk("rd_valid_early", issue_valid_out, 0);
        idle();
        step();
        chk("rd_valid", issue_valid_out, 1);
        chk("rd_op", issue_op_out, ALU_ADD);
        chk("rd_opr1", issue_opr1_out, 5);
        chk("rd_opr2", issue_opr2_out, 7);
        chk("rd_rob", issue_rob_id_out, 3);
        chk("rd_count0", count_out, 0);
        step();
        chk("rd_drain", issue_valid_out, 0);

        // wakeup of a waiting entry and dispatch bypass in the same cycle
        disp(ALU_ADD, 0, 1, 1, 0, 2, 0, 4);
        step();
        disp(ALU_SUB, 3, 0, 0, 1, 0, 2, 5);
        cdb(2'b01, 2, 0, 32'h55, 0);
        step();
        chk("wb_none_yet", issue_valid_out, 0);
        idle();
        step();
        chk("wb_rob_a", issue_rob_id_out, 4);
        chk("wb_opr1_a", issue_opr1_out, 32'h55);
        chk("wb_opr2_a", issue_opr2_out, 1);
        step();
        chk("wb_rob_b", issue_rob_id_out, 5);
        chk("wb_op_b", issue_op_out, ALU_SUB);
        chk("wb_opr1_b", issue_opr1_out, 3);
        chk("wb_opr2_b", issue_opr2_out, 32'h55);
        step();
        chk("wb_drain", issue_valid_out, 0);

        // younger ready op overtakes an older waiting one; duplicate tag takes channel 0
        disp(ALU_ADD, 0, 2, 1, 0, 9, 0, 1);
        step();
        disp(ALU_ADD, 10, 20, 0, 0, 0, 0, 2);
        step();
        idle();
        cdb(2'b11, 9, 9, 32'h99, 32'h11);
        step();
        chk("age_first", issue_rob_id_out, 2);
        chk("age_first_opr1", issue_opr1_out, 10);
        idle();
        step();
        chk("age_second", issue_rob_id_out, 1);
        chk("age_dup_ch0", issue_opr1_out, 32'h99);
        chk("age_opr2", issue_opr2_out, 2);
        step();
        chk("age_drain", issue_valid_out, 0);

        // both operands woken by different channels in one cycle
        disp(ALU_XOR, 0, 0, 1, 1, 6, 7, 6);
        step();
        idle();
        cdb(2'b11, 7, 6, 32'h70, 32'h60);
        step();
        idle();
        step();
        chk("dual_rob", issue_rob_id_out, 6);
        chk("dual_opr1", issue_opr1_out, 32'h60);
        chk("dual_opr2", issue_opr2_out, 32'h70);
        step();
        chk("dual_drain", issue_valid_out, 0);

        // fill under backpressure: issue register absorbs op 0, table holds ops 1..8
        issue_ready_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            disp(ALU_ADD, 32'(100 + k), 32'(200 + k), 0, 0, 0, 0, 4'(k));
            step();
        end
        chk("full_count", count_out, 8);
        chk("full_dready", disp_ready_out, 0);
        chk("full_valid", issue_valid_out, 1);
        chk("full_rob", issue_rob_id_out, 0);
        disp(ALU_OR, 109, 209, 0, 0, 0, 0, 9);
        step();
        step();
        chk("hold_count", count_out, 8);
        chk("hold_rob", issue_rob_id_out, 0);
        chk("hold_opr1", issue_opr1_out, 100);
        issue_ready_in = 1'b1;
        step();
        chk("rel_rob", issue_rob_id_out, 1);
        chk("rel_count", count_out, 7);
        idle();
        for (int k = 2; k < 9; k++) begin
            step();
            chk("drain_rob", issue_rob_id_out, 64'(k));
            chk("drain_opr1", issue_opr1_out, 64'(100 + k));
        end
        step();
        chk("drain_valid", issue_valid_out, 0);
        chk("drain_count", count_out, 0);

        // global freeze, then flush overriding a dispatch
        issue_ready_in = 1'b0;
        for (int k = 1; k < 6; k++) begin
            disp(ALU_ADD, 32'(k), 32'(k), 0, 0, 0, 0, 4'(k));
            step();
        end
        chk("fl_pre_count", count_out, 4);
        chk("fl_pre_valid", issue_valid_out, 1);
        rdy_in = 1'b0;
        issue_ready_in = 1'b1;
        disp(ALU_ADD, 1, 1, 0, 0, 0, 0, 12);
        cdb(2'b01, 3, 0, 32'h33, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("frz_count", count_out, 4);
            chk("frz_valid", issue_valid_out, 1);
            chk("frz_rob", issue_rob_id_out, 1);
        end
        rdy_in = 1'b1;
        issue_ready_in = 1'b0;
        flush_in = 1'b1;
        idle();
        disp(ALU_ADD, 1, 1, 0, 0, 0, 0, 12);
        step();
        chk("fl_count", count_out, 0);
        chk("fl_valid", issue_valid_out, 0);
        chk("fl_dready", disp_ready_out, 1);
        flush_in = 1'b0;
        idle();
        issue_ready_in = 1'b1;
        step();
        step();
        chk("fl_post_valid", issue_valid_out, 0);
        chk("fl_post_count", count_out, 0);

        // asynchronous reset in the middle of traffic
        issue_ready_in = 1'b0;
        for (int k = 1; k < 4; k++) begin
            disp(ALU_AND, 32'(k + 20), 0, 0, 0, 0, 0, 4'(k));
            step();
        end
        idle();
        chk("mr_pre_count", count_out, 2);
        chk("mr_pre_valid", issue_valid_out, 1);
        #3;
        rst_in = 1'b0;
        #1;
        chk("mr_count", count_out, 0);
        chk("mr_valid", issue_valid_out, 0);
        chk("mr_opr1", issue_opr1_out, 0);
        chk("mr_rob", issue_rob_id_out, 0);
        #2;
        rst_in = 1'b1;
        step();
        chk("mr_after", count_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
